// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Program sequencer that sits in front of the TinyCPU instruction decoder.
// It owns a small writable program memory of opcodes and a program counter.
// Under Run (continuous) or Step (single instruction) control it fetches one
// opcode at a time and presents it on `instruction`, qualified by a one-cycle
// InstrValid pulse. A dedicated halt opcode stops sequencing until Reset.
//
// Ports:
//   Clock       in   system clock, all state changes on the rising edge
//   Reset       in   synchronous active-high reset (program memory is kept)
//   Run         in   level; while high, fetch/issue continuously
//   Step        in   one-cycle pulse; issues a single opcode from IDLE
//   LoadEn      in   program-memory write enable (IDLE/HALTED only)
//   LoadAddr    in   program-memory write address
//   LoadData    in   program-memory write data
//   instruction out  registered opcode for the decoder
//   InstrValid  out  one-cycle qualifier for each issued opcode
//   PC          out  address of the opcode being fetched/issued
//   Busy        out  high while fetching or issuing
//   Halted      out  high once the halt opcode has been reached
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                     INSTR_WIDTH = 4,
    parameter int                     ADDR_WIDTH  = 4,
    parameter int                     PROG_DEPTH  = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_OPCODE = 4'hF
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Run,
    input  logic                   Step,
    input  logic                   LoadEn,
    input  logic [ADDR_WIDTH-1:0]  LoadAddr,
    input  logic [INSTR_WIDTH-1:0] LoadData,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   InstrValid,
    output logic [ADDR_WIDTH-1:0]  PC,
    output logic                   Busy,
    output logic                   Halted
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [INSTR_WIDTH-1:0] mem [PROG_DEPTH];

    logic load_ok;    // memory may be written in the current state
    logic advance_pc; // a non-halt opcode is being issued this cycle

    // -----------------------------------------------------------------------
    // Next-state and Moore outputs
    // -----------------------------------------------------------------------
    always_comb begin
        next_state = state;
        InstrValid = 1'b0;
        Busy       = 1'b0;
        Halted     = 1'b0;
        load_ok    = 1'b0;
        advance_pc = 1'b0;
        case (state)
            IDLE: begin
                load_ok = 1'b1;
                // A pending load keeps us idle so the program can't be
                // fetched while it is being rewritten.
                if (!LoadEn && (Run || Step)) begin
                    next_state = FETCH;
                end
            end
            FETCH: begin
                Busy       = 1'b1;
                next_state = ISSUE;
            end
            ISSUE: begin
                Busy = 1'b1;
                // The halt opcode is never handed to the decoder as valid.
                if (instruction == HALT_OPCODE) begin
                    next_state = HALTED;
                end else begin
                    InstrValid = 1'b1;
                    advance_pc = 1'b1;
                    next_state = Run ? FETCH : IDLE;
                end
            end
            HALTED: begin
                Halted  = 1'b1;
                load_ok = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State, program counter and instruction register
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            PC          <= '0;
            instruction <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH) begin
                instruction <= mem[PC];
            end
            // PROG_DEPTH == 2**ADDR_WIDTH, so natural overflow gives the wrap.
            if (advance_pc) begin
                PC <= PC + ADDR_WIDTH'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Program memory: deliberately outside reset so programs survive it
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (LoadEn && load_ok) begin
            mem[LoadAddr] <= LoadData;
        end
    end

endmodule
